iir_biquad_tdm: RTL and testbench
=================================

Name: iir_biquad_tdm

Overview:
- Runtime-programmable cascade of NSEC direct-form-I biquad sections.
- All sections are computed on one shared multiplier-accumulator, time-multiplexed per sample.
- Sits where fixed-coefficient per-section biquad chains sit today: sample stream in, filtered stream out.
- Adds valid/ready handshakes, a coefficient write port, rounding, saturation with a sticky flag, and delay-line clear.

Parameters:
- W, 32, data width; signed two's complement.
- CW, 32, coefficient width; signed.
- FSW, 16, fractional bits in coefficients.
- NSEC, 22, number of biquad sections (≥1).
- SAW, $clog2(NSEC) (min 1), section-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  W  input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  W  filtered sample.
- coef_we  in  1  coefficient write strobe.
- coef_sec  in  SAW  section index.
- coef_idx  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_wdata  in  CW  coefficient value, FSW fractional bits.
- clr  in  1  clear delay line (honoured in IDLE only).
- coef_drop  out  1  one-cycle pulse when a coef write is ignored.
- sat  out  1  sticky saturation flag.
- sat_clr  in  1  clears sat.

Behaviour:
- Reset (async, rst_n=0):
  - FSM→IDLE; in_ready=1, out_valid=0, out_data=0, sat=0, coef_drop=0.
  - Delay line zeroed.
  - Coefficients reset to pass-through: b0=1<<FSW, all others 0.
- Delay line d[0..NSEC], each entry holding z1, z2. Section k takes d[k] as input history and d[k+1] as output history.
- FSM states: IDLE, MAC, WB, DONE.
  - IDLE: in_ready=1. On in_valid: xcur←in_data, k←0, t←0, acc←0 → MAC.
  - MAC: one product per cycle, in order t=0..4: b0·xcur, b1·d[k].z1, b2·d[k].z2, −a1·d[k+1].z1, −a2·d[k+1].z2. After t=4 → WB.
  - WB:
    - y = sat_W((acc + 2^(FSW−1)) >>> FSW).
    - d[k].z2←d[k].z1, d[k].z1←xcur, xcur←y.
    - If k=NSEC−1: also shift d[NSEC] with y, out_data←y, out_valid←1 → DONE.
    - Otherwise k←k+1, acc←0 → MAC.
  - DONE: out_valid=1, out_data held stable, in_ready=0. On out_ready: out_valid←0 → IDLE. No same-cycle bypass to a new input.
- Latency: 6·NSEC cycles from the input-accept edge to out_valid high. Throughput is one sample per 6·NSEC+2 cycles minimum.
- Arithmetic:
  - Products are W+CW bits.
  - Accumulator is ACCW=W+CW+3 bits, sign-extended; no overflow is possible.
  - Rounding is round-half-up.
- Saturation: results above 2^(W−1)−1 clamp to 0x7FF…; results below −2^(W−1) clamp to 0x800…. Any clamp sets sat. sat_clr clears it; a clamp in the same cycle as sat_clr wins.
- Coefficient writes:
  - Applied on the clock edge, in IDLE only.
  - Writes in other states, with coef_sec≥NSEC, or with coef_idx>4 are ignored and pulse coef_drop.
- clr in IDLE zeroes the delay line. If in_valid arrives in the same cycle, clr applies first and the sample is accepted against the cleared state. clr is ignored outside IDLE.
- Reset mid-computation aborts the sample; no output is produced.

Decomposition:
- Shared package iir_pkg:
  - Coefficient index constants (CI_B0..CI_A2).
  - State enum.
  - ACCW function.
  - Saturate/round function, shared with the existing biquad code.
- One sub-module, iir_mac_round: registered multiply-accumulate with clear, plus round/saturate output and overflow flag.
- Top level holds the FSM, the coefficient register file, and the delay line.

Test Plan:
(all with W=32, CW=32, FSW=16, NSEC=2)
- Reset defaults: in_data=0x0001_0000 → out_data=0x0001_0000; out_valid exactly 12 cycles after accept; sat=0.
- Rounding: write sec0 b0=0x8000 (0.5). in=0x0000_0001 → out=0x0000_0001 (half rounds up). in=0x0002_0000 → out=0x0001_0000.
- Feedback: sec0 b0=0x10000, a1=0xFFFF_8000 (−0.5). Impulse 0x10000 then zeros → outputs 0x10000, 0x8000, 0x4000, 0x2000.
- Saturation: sec0 b0=0x40000 (4.0).
  - in=0x4000_0000 → out=0x7FFF_FFFF, sat=1.
  - in=0xC000_0000 → out=0x8000_0000.
  - sat_clr → sat=0.
- Backpressure/drops: hold out_ready=0 for 20 cycles → out_valid and out_data stable, in_ready=0. coef_we during MAC → coef_drop pulse and coefficient unchanged. coef_idx=5 in IDLE → coef_drop.
- Reset mid-MAC: deassert rst_n at cycle 4 of a sample → after release in_ready=1, out_valid=0, coefficients back to pass-through, next sample passes unchanged.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: shared constants, FSM state type and arithmetic helpers for the TDM biquad cascade
package iir_pkg;
  localparam logic [2:0] CI_B0 = 3'd0;
  localparam logic [2:0] CI_B1 = 3'd1;
  localparam logic [2:0] CI_B2 = 3'd2;
  localparam logic [2:0] CI_A1 = 3'd3;
  localparam logic [2:0] CI_A2 = 3'd4;
  localparam int RMAX = 128;
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  function automatic int accw(input int w, input int cw);
    return w + cw + 3;
  endfunction
  // Round half-up by fsw fractional bits, then clamp to a signed w-bit range; ovf reports a clamp.
  function automatic logic signed [RMAX-1:0] sat_round(input logic signed [RMAX-1:0] acc,
                                                       input int w, input int fsw,
                                                       output logic ovf);
    logic signed [RMAX-1:0] one, r, hi, lo;
    one = 1;
    r = (acc + (one <<< (fsw - 1))) >>> fsw;
    hi = (one <<< (w - 1)) - one;
    lo = -hi - one;
    ovf = (r > hi) || (r < lo);
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/iir_mac_round.sv
// iir_mac_round: registered signed multiply-accumulate with clear, round/saturate output and clamp flag
// ports: clk, rst_n (async low), clr (zero acc), en (accumulate), sub (subtract product),
//        a (W data), b (CW coef), y (rounded/saturated acc), ovf (y was clamped)
module iir_mac_round import iir_pkg::*; #(
  parameter int W = 32,
  parameter int CW = 32,
  parameter int FSW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sub,
  input  logic signed [W-1:0]  a,
  input  logic signed [CW-1:0] b,
  output logic signed [W-1:0]  y,
  output logic                 ovf
);
  localparam int ACCW = accw(W, CW);
  logic signed [W+CW-1:0] prod;
  logic signed [ACCW-1:0] acc, prod_x;
  assign prod = a * b;
  assign prod_x = {{3{prod[W+CW-1]}}, prod};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sub ? acc - prod_x : acc + prod_x;
  always_comb begin
    ovf = 1'b0;
    y = W'(sat_round(RMAX'(acc), W, FSW, ovf));
  end
endmodule

// File: rtl/iir_biquad_tdm.sv
// iir_biquad_tdm: programmable DF-I biquad cascade sharing one MAC across NSEC sections per sample
// ports: clk, rst_n (async low); in_valid/in_ready/in_data sample input; out_valid/out_ready/out_data
//        filtered output; coef_we/coef_sec/coef_idx/coef_wdata coefficient write (IDLE only);
//        clr delay-line clear (IDLE only); coef_drop ignored-write pulse; sat/sat_clr sticky clamp flag
module iir_biquad_tdm import iir_pkg::*; #(
  parameter int W = 32,
  parameter int CW = 32,
  parameter int FSW = 16,
  parameter int NSEC = 22,
  parameter int SAW = (NSEC > 1) ? $clog2(NSEC) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  input  logic           coef_we,
  input  logic [SAW-1:0] coef_sec,
  input  logic [2:0]     coef_idx,
  input  logic [CW-1:0]  coef_wdata,
  input  logic           clr,
  output logic           coef_drop,
  output logic           sat,
  input  logic           sat_clr
);
  localparam int DAW = $clog2(NSEC + 1);
  state_t state;
  logic [SAW-1:0] k;
  logic [2:0] t;
  logic signed [W-1:0] xcur, mul_a, y;
  logic signed [CW-1:0] mul_b;
  logic signed [CW-1:0] coef [NSEC][5];
  logic signed [W-1:0] z1 [NSEC+1];
  logic signed [W-1:0] z2 [NSEC+1];
  logic [DAW-1:0] ki, ko;
  logic coef_ok, last, ovf;
  assign ki = DAW'(k);
  assign ko = ki + DAW'(1);
  assign last = int'(k) == NSEC - 1;
  assign in_ready = state == IDLE;
  assign coef_ok = coef_we && state == IDLE && int'(coef_sec) < NSEC && coef_idx <= CI_A2;
  // Section k reads its input history from d[k] and its output history from d[k+1].
  assign mul_a = t == CI_B0 ? xcur : t == CI_B1 ? z1[ki] : t == CI_B2 ? z2[ki] :
                 t == CI_A1 ? z1[ko] : z2[ko];
  assign mul_b = coef[k][t];
  iir_mac_round #(.W(W), .CW(CW), .FSW(FSW)) u_mac (
    .clk(clk),
    .rst_n(rst_n),
    .clr((state == IDLE && in_valid) || (state == WB && !last)),
    .en(state == MAC),
    .sub(t >= CI_A1),
    .a(mul_a),
    .b(mul_b),
    .y(y),
    .ovf(ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      t <= '0;
      xcur <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      sat <= 1'b0;
      coef_drop <= 1'b0;
      for (int i = 0; i <= NSEC; i++) begin
        z1[i] <= '0;
        z2[i] <= '0;
      end
      for (int i = 0; i < NSEC; i++)
        for (int j = 0; j < 5; j++)
          coef[i][j] <= (j == 0) ? CW'(1) <<< FSW : '0;
    end else begin
      coef_drop <= coef_we && !coef_ok;
      if (coef_ok) coef[coef_sec][coef_idx] <= coef_wdata;
      if (state == WB && ovf) sat <= 1'b1;
      else if (sat_clr) sat <= 1'b0;
      case (state)
        IDLE: begin
          if (clr)
            for (int i = 0; i <= NSEC; i++) begin
              z1[i] <= '0;
              z2[i] <= '0;
            end
          if (in_valid) begin
            xcur <= in_data;
            k <= '0;
            t <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          t <= t + 3'd1;
          if (t == CI_A2) begin
            t <= '0;
            state <= WB;
          end
        end
        WB: begin
          z2[ki] <= z1[ki];
          z1[ki] <= xcur;
          xcur <= y;
          if (last) begin
            z2[ko] <= z1[ko];
            z1[ko] <= y;
            out_data <= y;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + SAW'(1);
            state <= MAC;
          end
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_biquad_tdm.sv
// tb_iir_biquad_tdm: directed self-checking bench for the TDM biquad cascade (NSEC=2)
module tb_iir_biquad_tdm;
  localparam int W = 32;
  localparam int CW = 32;
  localparam int FSW = 16;
  localparam int NSEC = 2;
  localparam int SAW = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic coef_we = 1'b0;
  logic [SAW-1:0] coef_sec = '0;
  logic [2:0] coef_idx = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic clr = 1'b0;
  logic coef_drop;
  logic sat;
  logic sat_clr = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  iir_biquad_tdm #(.W(W), .CW(CW), .FSW(FSW), .NSEC(NSEC), .SAW(SAW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .coef_we(coef_we),
    .coef_sec(coef_sec),
    .coef_idx(coef_idx),
    .coef_wdata(coef_wdata),
    .clr(clr),
    .coef_drop(coef_drop),
    .sat(sat),
    .sat_clr(sat_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    coef_we = 1'b0;
    clr = 1'b0;
    sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wr(input int sec, input int idx, input logic [CW-1:0] v);
    coef_we = 1'b1;
    coef_sec = SAW'(sec);
    coef_idx = 3'(idx);
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask
  task automatic send(input logic [W-1:0] x, input logic c, output logic [W-1:0] y, output int lat);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    in_data = x;
    in_valid = 1'b1;
    clr = c;
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout: out_valid=%b, required 1 within 200 cycles", out_valid);
    end
    y = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    logic [W-1:0] y;
    int lat;
    do_reset();
    n_cmp++;
    if ({in_ready, out_valid, sat, coef_drop} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags: in_ready/out_valid/sat/coef_drop=%b, required 1000",
               {in_ready, out_valid, sat, coef_drop});
    end
    n_cmp++;
    if (out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out_data: got %h, required 00000000", out_data);
    end
    send(32'h0001_0000, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h0001_0000) begin
      n_bad++;
      $display("FAIL reset_passthrough: got %h, required 00010000", y);
    end
    n_cmp++;
    if (lat !== 12) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required 12", lat);
    end
    n_cmp++;
    if (sat !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_sat: got %b, required 0", sat);
    end
  endtask
  task automatic test_rounding();
    logic [W-1:0] y;
    int lat;
    do_reset();
    wr(0, 0, 32'h0000_8000);
    n_cmp++;
    if (coef_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL legal_write_drop: got %b, required 0", coef_drop);
    end
    send(32'h0000_0001, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL round_half_up: got %h, required 00000001", y);
    end
    send(32'h0002_0000, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h0001_0000) begin
      n_bad++;
      $display("FAIL round_half_scale: got %h, required 00010000", y);
    end
  endtask
  task automatic test_feedback();
    logic [W-1:0] y;
    logic [W-1:0] e [4];
    int lat;
    e = '{32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000};
    do_reset();
    wr(0, 0, 32'h0001_0000);
    wr(0, 3, 32'hFFFF_8000);
    for (int i = 0; i < 4; i++) begin
      send(i == 0 ? 32'h0001_0000 : 32'h0, 1'b0, y, lat);
      n_cmp++;
      if (y !== e[i]) begin
        n_bad++;
        $display("FAIL feedback[%0d]: got %h, required %h", i, y, e[i]);
      end
    end
    send(32'h0, 1'b1, y, lat);
    n_cmp++;
    if (y !== 32'h0) begin
      n_bad++;
      $display("FAIL clr_with_sample: got %h, required 00000000", y);
    end
  endtask
  task automatic test_saturation();
    logic [W-1:0] y;
    int lat;
    do_reset();
    wr(0, 0, 32'h0004_0000);
    send(32'h4000_0000, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h7FFF_FFFF || sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_pos: got %h sat=%b, required 7fffffff sat=1", y, sat);
    end
    send(32'hC000_0000, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h8000_0000 || sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_neg: got %h sat=%b, required 80000000 sat=1", y, sat);
    end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    n_cmp++;
    if (sat !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clr: got %b, required 0", sat);
    end
  endtask
  task automatic test_backpressure();
    logic [W-1:0] y;
    int lat;
    int g;
    do_reset();
    in_data = 32'h0001_2345;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1;
    coef_sec = '0;
    coef_idx = 3'd0;
    coef_wdata = 32'h0003_0000;
    @(negedge clk);
    coef_we = 1'b0;
    n_cmp++;
    if (coef_drop !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_in_mac: got %b, required 1", coef_drop);
    end
    @(negedge clk);
    n_cmp++;
    if (coef_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_pulse_width: got %b, required 0", coef_drop);
    end
    g = 0;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (out_data !== 32'h0001_2345 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL coef_unchanged: got %h valid=%b, required 00012345 valid=1", out_data, out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h0001_2345 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold[%0d]: valid=%b data=%h in_ready=%b, required 1 00012345 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    wr(0, 5, 32'h0003_0000);
    n_cmp++;
    if (coef_drop !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_bad_idx: got %b, required 1", coef_drop);
    end
    send(32'h0001_2345, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h0001_2345) begin
      n_bad++;
      $display("FAIL after_drops: got %h, required 00012345", y);
    end
  endtask
  task automatic test_reset_mid();
    logic [W-1:0] y;
    int lat;
    do_reset();
    wr(0, 0, 32'h0003_0000);
    in_data = 32'h0000_1000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_state: in_ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL aborted_sample[%0d]: valid=%b, required 0", i, out_valid);
      end
    end
    send(32'h0001_2345, 1'b0, y, lat);
    n_cmp++;
    if (y !== 32'h0001_2345) begin
      n_bad++;
      $display("FAIL mid_reset_passthrough: got %h, required 00012345", y);
    end
  endtask
  initial begin
    test_reset();
    test_rounding();
    test_feedback();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
